plab4_net_ring_tdm_sched: RTL and testbench
===========================================

# plab4_net_ring_tdm_sched

Time-division domain scheduler for the two-router, two-domain (D1/D2) ring network. It owns the global slot schedule deciding which security domain may inject into the ring each cycle. It inserts a fixed drain window before every domain switch so in-flight traffic clears. It tracks per-domain in-flight message counts and flags any message that survives a switch. The schedule is fixed and independent of traffic, which closes the occupancy timing channel of the unprotected ring. It sits beside the ring and drives the injection gates and the per-link domain selects of both routers.

## Interface
Parameters:
- p_slot_cycles, 16, total cycles per domain slot (ACTIVE + DRAIN); must be ≥ 2.
- p_drain_cycles, 4, cycles at end of each slot with injection blocked; 1 ≤ p_drain_cycles < p_slot_cycles.
- p_cnt_nbits, 6, width of the per-domain in-flight counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0.
- en  in  1  scheduler enable; sampled at slot boundaries only.
- inj_cnt_d0  in  2  domain-D1 injections accepted this cycle, summed over both routers' terminal val&rdy (0..2).
- ej_cnt_d0  in  2  domain-D1 ejections this cycle at out_ter ports (0..2).
- inj_cnt_d1  in  2  domain-D2 injections this cycle (0..2).
- ej_cnt_d1  in  2  domain-D2 ejections this cycle (0..2).
- cur_domain  out  1  owning domain; 0 = D1, 1 = D2; drives all outN_domain selects.
- inj_en_d0  out  1  D1 terminal injection allowed.
- inj_en_d1  out  1  D2 terminal injection allowed.
- slot_start  out  1  one-cycle pulse on the first cycle of each ACTIVE phase.
- drain  out  1  high during the DRAIN phase.
- inflight_d0  out  p_cnt_nbits  D1 messages in the ring.
- inflight_d1  out  p_cnt_nbits  D2 messages in the ring.
- leak_err  out  1  sticky; a violation has occurred.

## Operation
- States: IDLE, ACTIVE, DRAIN. The slot counter slot_cnt runs 0..p_slot_cycles-1.
- IDLE:
  - All outputs are held at reset values, except cur_domain and the counters, which are held.
  - If en=1, move to ACTIVE with slot_cnt=0.
- ACTIVE:
  - inj_en_dX = (cur_domain==X).
  - slot_start=1 when slot_cnt==0.
  - When slot_cnt == p_slot_cycles-p_drain_cycles-1, move to DRAIN.
- DRAIN:
  - drain=1; both inj_en low.
  - On slot_cnt == p_slot_cycles-1:
    - Leak check: if the updated inflight of cur_domain ≠ 0, set leak_err.
    - Toggle cur_domain and clear slot_cnt.
    - Move to ACTIVE if en=1, otherwise IDLE.
- In-flight counters (always active, all states): inflight_dX ← inflight_dX + inj_cnt_dX − ej_cnt_dX.
  - Computed in p_cnt_nbits+2 signed width.
  - Result < 0: clamp to 0 and set leak_err.
  - Result > 2^p_cnt_nbits−1: saturate and set leak_err.
- An injection while the matching inj_en is low (inj_cnt_dX≠0) sets leak_err.
- leak_err clears only on reset.

## Timing
- Reset values:
  - State IDLE, cur_domain=0, slot_cnt=0.
  - inj_en_d0=inj_en_d1=0, slot_start=0, drain=0.
  - inflight_d0=inflight_d1=0, leak_err=0.
- All outputs are registered-state decodes with no combinational input→output path, so the ring sees gates valid from the start of the cycle.
- en=1 sampled in IDLE at edge N → ACTIVE with slot_start=1 in cycle N+1.
- Slot cycle counts:
  - Each slot is exactly p_slot_cycles cycles: p_slot_cycles−p_drain_cycles ACTIVE, then p_drain_cycles DRAIN.
  - The next slot_start follows with zero gap.
- Deasserting en mid-slot does not shorten the slot; the block goes to IDLE after the drain completes.
- Injection and ejection in the same cycle are both counted; the net change is applied.
- Reset low mid-slot → reset values on the next edge, regardless of state.

## Structure
- Shared package plab4_net_tdm_pkg holds:
  - State encoding constants (IDLE=2'd0, ACTIVE=2'd1, DRAIN=2'd2).
  - Domain constants D1=1'b0, D2=1'b1.
- One sub-module, plab4_net_inflight_ctr, instantiated per domain: saturating/clamping up-down counter with an error output.
- Scheduler FSM and slot counter live in the top module.

## Test plan
- Reset, then en=1 held, no traffic:
  - slot_start pulses every 16 cycles.
  - inj_en_d0 high for cycles 0–11 of slot 0; drain high for cycles 12–15.
  - cur_domain toggles to 1 at cycle 16; inj_en_d1 high for cycles 16–27.
  - leak_err stays 0.
- D1 injects 2 msgs in slot cycle 3 and ejects 1 each in cycles 6 and 13 → inflight_d0 = 2, 2, 1, 0; no leak_err at switch.
- D1 injects 1 msg in cycle 11 with no ejection before cycle 15 → leak_err=1 at the switch edge and stays 1.
- inj_cnt_d1=1 while cur_domain=0 → leak_err=1 next cycle.
- ej_cnt_d0=1 with inflight_d0=0 → inflight_d0 stays 0, leak_err=1.
- Control boundaries:
  - en dropped at slot cycle 5 → drain still runs cycles 12–15, then IDLE with both inj_en 0 and cur_domain=1 held.
  - reset pulsed low at cycle 9 → all reset values on the next cycle.

Source files
------------

// File: rtl/plab4_net_tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : plab4_net_tdm_pkg
//  Purpose  : Shared encodings for the ring TDM domain scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package plab4_net_tdm_pkg;

  typedef logic [1:0] tdm_state_t;

  localparam tdm_state_t IDLE   = 2'd0;
  localparam tdm_state_t ACTIVE = 2'd1;
  localparam tdm_state_t DRAIN  = 2'd2;

  localparam logic D1 = 1'b0;
  localparam logic D2 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/plab4_net_ring_tdm_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : plab4_net_ring_tdm_sched_if
//  Purpose  : Traffic counts in, injection gates and status out.
//  Revision : 1.0 - initial release
// ============================================================================
interface plab4_net_ring_tdm_sched_if #(
  parameter int p_cnt_nbits = 6
);
  logic                   en;
  logic [1:0]             inj_cnt_d0;
  logic [1:0]             ej_cnt_d0;
  logic [1:0]             inj_cnt_d1;
  logic [1:0]             ej_cnt_d1;
  logic                   cur_domain;
  logic                   inj_en_d0;
  logic                   inj_en_d1;
  logic                   slot_start;
  logic                   drain;
  logic [p_cnt_nbits-1:0] inflight_d0;
  logic [p_cnt_nbits-1:0] inflight_d1;
  logic                   leak_err;

  // Scheduler side
  modport master (
    input  en, inj_cnt_d0, ej_cnt_d0, inj_cnt_d1, ej_cnt_d1,
    output cur_domain, inj_en_d0, inj_en_d1, slot_start, drain,
           inflight_d0, inflight_d1, leak_err
  );

  // Ring side
  modport slave (
    output en, inj_cnt_d0, ej_cnt_d0, inj_cnt_d1, ej_cnt_d1,
    input  cur_domain, inj_en_d0, inj_en_d1, slot_start, drain,
           inflight_d0, inflight_d1, leak_err
  );
endinterface
`default_nettype wire

// File: rtl/plab4_net_inflight_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : plab4_net_inflight_ctr
//  Purpose  : Per-domain in-flight counter; clamps at 0, saturates at max.
//  Revision : 1.0 - initial release
// ============================================================================
module plab4_net_inflight_ctr #(
  parameter int p_cnt_nbits = 6
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             inj_cnt,
  input  logic [1:0]             ej_cnt,
  output logic [p_cnt_nbits-1:0] count,
  output logic [p_cnt_nbits-1:0] count_next,
  output logic                   err
);
  localparam int c_sum_w = p_cnt_nbits + 2;
  localparam logic signed [c_sum_w-1:0] c_max_s = $signed({2'b00, {p_cnt_nbits{1'b1}}});

  logic [p_cnt_nbits-1:0]    r_count;
  logic signed [c_sum_w-1:0] w_sum;

  // Two guard bits hold the full -2..max+2 range of one update.
  always_comb begin
    w_sum      = $signed({2'b00, r_count})
               + $signed({{p_cnt_nbits{1'b0}}, inj_cnt})
               - $signed({{p_cnt_nbits{1'b0}}, ej_cnt});
    count_next = w_sum[p_cnt_nbits-1:0];
    err        = 1'b0;
    if (w_sum[c_sum_w-1]) begin
      count_next = '0;
      err        = 1'b1;
    end else if (w_sum > c_max_s) begin
      count_next = {p_cnt_nbits{1'b1}};
      err        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_count <= '0;
    else        r_count <= count_next;
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/plab4_net_ring_tdm_sched.sv
`default_nettype none
// ============================================================================
//  Module   : plab4_net_ring_tdm_sched
//  Purpose  : Fixed slot schedule with drain window for the two-domain ring.
//  Revision : 1.0 - initial release
// ============================================================================
module plab4_net_ring_tdm_sched
  import plab4_net_tdm_pkg::*;
#(
  parameter int p_slot_cycles  = 16,
  parameter int p_drain_cycles = 4,
  parameter int p_cnt_nbits    = 6
)(
  input  logic                       clk,
  input  logic                       reset,
  plab4_net_ring_tdm_sched_if.master bus
);
  localparam int c_slot_w = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
  localparam logic [c_slot_w-1:0] c_act_last  = c_slot_w'(p_slot_cycles - p_drain_cycles - 1);
  localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(p_slot_cycles - 1);

  tdm_state_t            r_state;
  logic [c_slot_w-1:0]   r_slot_cnt;
  logic                  r_cur_domain;
  logic                  r_leak_err;

  logic                   w_inj_en_d0;
  logic                   w_inj_en_d1;
  logic                   w_switch;
  logic                   w_switch_leak;
  logic                   w_gate_err;
  logic                   w_ctr_err_d0;
  logic                   w_ctr_err_d1;
  logic [p_cnt_nbits-1:0] w_next_d0;
  logic [p_cnt_nbits-1:0] w_next_d1;

  plab4_net_inflight_ctr #(.p_cnt_nbits(p_cnt_nbits)) u_ctr_d0 (
    .clk        (clk),
    .reset      (reset),
    .inj_cnt    (bus.inj_cnt_d0),
    .ej_cnt     (bus.ej_cnt_d0),
    .count      (bus.inflight_d0),
    .count_next (w_next_d0),
    .err        (w_ctr_err_d0)
  );

  plab4_net_inflight_ctr #(.p_cnt_nbits(p_cnt_nbits)) u_ctr_d1 (
    .clk        (clk),
    .reset      (reset),
    .inj_cnt    (bus.inj_cnt_d1),
    .ej_cnt     (bus.ej_cnt_d1),
    .count      (bus.inflight_d1),
    .count_next (w_next_d1),
    .err        (w_ctr_err_d1)
  );

  // Gates decode registered state only, so they are valid from cycle start.
  assign w_inj_en_d0 = (r_state == ACTIVE) && (r_cur_domain == D1);
  assign w_inj_en_d1 = (r_state == ACTIVE) && (r_cur_domain == D2);

  assign w_switch      = (r_state == DRAIN) && (r_slot_cnt == c_slot_last);
  assign w_switch_leak = w_switch &&
                         ((r_cur_domain == D1) ? (w_next_d0 != '0) : (w_next_d1 != '0));
  assign w_gate_err    = ((bus.inj_cnt_d0 != 2'd0) && !w_inj_en_d0) ||
                         ((bus.inj_cnt_d1 != 2'd0) && !w_inj_en_d1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_slot_cnt   <= '0;
      r_cur_domain <= D1;
      r_leak_err   <= 1'b0;
    end else begin
      if (w_switch_leak || w_gate_err || w_ctr_err_d0 || w_ctr_err_d1)
        r_leak_err <= 1'b1;

      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_state    <= ACTIVE;
            r_slot_cnt <= '0;
          end
        end
        ACTIVE: begin
          r_slot_cnt <= r_slot_cnt + 1'b1;
          if (r_slot_cnt == c_act_last) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_switch) begin
            r_cur_domain <= ~r_cur_domain;
            r_slot_cnt   <= '0;
            r_state      <= bus.en ? ACTIVE : IDLE;
          end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_slot_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.cur_domain = r_cur_domain;
  assign bus.inj_en_d0  = w_inj_en_d0;
  assign bus.inj_en_d1  = w_inj_en_d1;
  assign bus.slot_start = (r_state == ACTIVE) && (r_slot_cnt == '0);
  assign bus.drain      = (r_state == DRAIN);
  assign bus.leak_err   = r_leak_err;

endmodule
`default_nettype wire

// File: tb/tb_plab4_net_ring_tdm_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plab4_net_ring_tdm_sched
//  Purpose  : Directed self-checking bench for the ring TDM scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_plab4_net_ring_tdm_sched;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  plab4_net_ring_tdm_sched_if #(.p_cnt_nbits(6)) bus ();

  plab4_net_ring_tdm_sched #(
    .p_slot_cycles  (16),
    .p_drain_cycles (4),
    .p_cnt_nbits    (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic clear_traffic();
    bus.inj_cnt_d0 = 2'd0;
    bus.ej_cnt_d0  = 2'd0;
    bus.inj_cnt_d1 = 2'd0;
    bus.ej_cnt_d1  = 2'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dom"},   32'(bus.cur_domain),  32'd0);
    chk({tag, "_ien0"},  32'(bus.inj_en_d0),   32'd0);
    chk({tag, "_ien1"},  32'(bus.inj_en_d1),   32'd0);
    chk({tag, "_start"}, 32'(bus.slot_start),  32'd0);
    chk({tag, "_drain"}, 32'(bus.drain),       32'd0);
    chk({tag, "_if0"},   32'(bus.inflight_d0), 32'd0);
    chk({tag, "_if1"},   32'(bus.inflight_d1), 32'd0);
    chk({tag, "_leak"},  32'(bus.leak_err),    32'd0);
  endtask

  // Reset for two cycles, then enable; cycle 0 is the first ACTIVE cycle.
  task automatic reset_start();
    clear_traffic();
    reset  = 1'b0;
    bus.en = 1'b0;
    tick();
    tick();
    reset  = 1'b1;
    bus.en = 1'b1;
    tick();
    cyc = 0;
  endtask

  task automatic chk_sched(input int c);
    int p;
    int dom;
    p   = c % 16;
    dom = (c / 16) % 2;
    chk("sched_start", 32'(bus.slot_start), 32'(p == 0));
    chk("sched_ien0",  32'(bus.inj_en_d0),  32'((p < 12) && (dom == 0)));
    chk("sched_ien1",  32'(bus.inj_en_d1),  32'((p < 12) && (dom == 1)));
    chk("sched_drain", 32'(bus.drain),      32'(p >= 12));
    chk("sched_dom",   32'(bus.cur_domain), 32'(dom));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    reset   = 1'b0;
    bus.en  = 1'b0;
    clear_traffic();

    // Reset values
    tick();
    tick();
    chk_reset_vals("rst");

    // Free-running schedule, no traffic
    reset  = 1'b1;
    bus.en = 1'b1;
    tick();
    cyc = 0;
    chk_sched(0);
    for (int c = 1; c < 33; c++) begin
      tick();
      chk_sched(c);
    end
    chk("sched_noleak", 32'(bus.leak_err), 32'd0);

    // D1 traffic drained within its slot (slot 2 = cycles 32..47)
    run_to(35);
    bus.inj_cnt_d0 = 2'd2;
    tick();
    bus.inj_cnt_d0 = 2'd0;
    chk("tr_inj2", 32'(bus.inflight_d0), 32'd2);
    run_to(38);
    chk("tr_hold2", 32'(bus.inflight_d0), 32'd2);
    bus.ej_cnt_d0 = 2'd1;
    tick();
    bus.ej_cnt_d0 = 2'd0;
    chk("tr_ej1", 32'(bus.inflight_d0), 32'd1);
    run_to(45);
    bus.ej_cnt_d0 = 2'd1;
    tick();
    bus.ej_cnt_d0 = 2'd0;
    chk("tr_ej0", 32'(bus.inflight_d0), 32'd0);
    run_to(48);
    chk("tr_dom1", 32'(bus.cur_domain), 32'd1);
    chk("tr_noleak", 32'(bus.leak_err), 32'd0);

    // Message surviving the switch (slot 4 = cycles 64..79)
    run_to(75);
    chk("sv_ien0_last", 32'(bus.inj_en_d0), 32'd1);
    bus.inj_cnt_d0 = 2'd1;
    tick();
    bus.inj_cnt_d0 = 2'd0;
    chk("sv_if1", 32'(bus.inflight_d0), 32'd1);
    run_to(79);
    chk("sv_pre_leak", 32'(bus.leak_err), 32'd0);
    tick();
    chk("sv_leak", 32'(bus.leak_err), 32'd1);
    chk("sv_dom", 32'(bus.cur_domain), 32'd1);
    bus.ej_cnt_d0 = 2'd1;
    tick();
    bus.ej_cnt_d0 = 2'd0;
    chk("sv_if0", 32'(bus.inflight_d0), 32'd0);
    chk("sv_sticky", 32'(bus.leak_err), 32'd1);

    // Off-schedule injection by D2
    reset_start();
    chk("gate_start", 32'(bus.slot_start), 32'd1);
    run_to(2);
    chk("gate_pre", 32'(bus.leak_err), 32'd0);
    bus.inj_cnt_d1 = 2'd1;
    tick();
    bus.inj_cnt_d1 = 2'd0;
    chk("gate_leak", 32'(bus.leak_err), 32'd1);
    chk("gate_if1", 32'(bus.inflight_d1), 32'd1);

    // Ejection underflow clamps at zero
    reset_start();
    run_to(1);
    chk("uf_pre", 32'(bus.leak_err), 32'd0);
    bus.ej_cnt_d0 = 2'd1;
    tick();
    bus.ej_cnt_d0 = 2'd0;
    chk("uf_if0", 32'(bus.inflight_d0), 32'd0);
    chk("uf_leak", 32'(bus.leak_err), 32'd1);

    // en dropped mid-slot: drain still runs, then IDLE on D2
    reset_start();
    run_to(5);
    bus.en = 1'b0;
    tick();
    chk("en_act6", 32'(bus.inj_en_d0), 32'd1);
    run_to(12);
    chk("en_drain12", 32'(bus.drain), 32'd1);
    chk("en_ien12", 32'(bus.inj_en_d0), 32'd0);
    run_to(15);
    chk("en_drain15", 32'(bus.drain), 32'd1);
    tick();
    chk("en_idle_drain", 32'(bus.drain), 32'd0);
    chk("en_idle_ien0", 32'(bus.inj_en_d0), 32'd0);
    chk("en_idle_ien1", 32'(bus.inj_en_d1), 32'd0);
    chk("en_idle_start", 32'(bus.slot_start), 32'd0);
    chk("en_idle_dom", 32'(bus.cur_domain), 32'd1);
    run_to(20);
    chk("en_idle_hold", 32'(bus.cur_domain), 32'd1);
    bus.en = 1'b1;
    tick();
    chk("en_resume_start", 32'(bus.slot_start), 32'd1);
    chk("en_resume_ien1", 32'(bus.inj_en_d1), 32'd1);
    chk("en_resume_leak", 32'(bus.leak_err), 32'd0);

    // Reset pulsed mid-slot with dirty state
    reset_start();
    run_to(2);
    bus.inj_cnt_d0 = 2'd1;
    tick();
    bus.inj_cnt_d0 = 2'd0;
    bus.inj_cnt_d1 = 2'd1;
    tick();
    bus.inj_cnt_d1 = 2'd0;
    chk("mr_dirty_leak", 32'(bus.leak_err), 32'd1);
    chk("mr_dirty_if0", 32'(bus.inflight_d0), 32'd1);
    run_to(9);
    reset = 1'b0;
    tick();
    chk_reset_vals("mr");
    reset = 1'b1;
    tick();
    chk("mr_restart", 32'(bus.slot_start), 32'd1);
    chk("mr_restart_ien0", 32'(bus.inj_en_d0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
